pll_reset_sequencer: RTL and testbench

Sits between the PLL and the per-domain reset synchronizers. It owns the PLL reset, waits for a stable PLL lock, and then releases the downstream domain resets one stage at a time in a fixed order. If lock is lost, it re-asserts every stage reset together and restarts the PLL. Its o_stage_reset_n outputs feed the async reset_n inputs of the sync_async_reset instances, one per stage.

---
 rtl/pll_reset_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Owns the PLL areset, waits for a stable (synchronized) lock, then releases
//   the per-domain resets one stage at a time, bit 0 first. Losing lock while
//   releasing or running re-asserts every stage reset and restarts the PLL.
//
// Ports
//   i_clk             free-running quartz clock (not PLL-derived)
//   i_reset           synchronous reset, active-high
//   i_pll_locked      PLL lock, asynchronous to i_clk (2-flop synchronized)
//   o_pll_reset       PLL areset, active-high
//   o_stage_reset_n   per-stage reset, active-low, bit 0 released first
//   o_all_ready       high only while every stage is released (RUN)
//   o_lock_lost_count lock losses seen in RELEASE/RUN, saturating at 255
//   o_fault           retry limit exhausted (constant 0 without the macro)
//
// Build option
//   PLL_SEQ_RETRY_LIMIT_EN : after MAX_RETRIES consecutive lock timeouts the
//   sequencer parks in FAULT until i_reset. Undefined: unlimited retries.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// ST_PLL_RESET   | PLL areset held for PLL_RESET_CYCLES
// ST_WAIT_LOCK   | areset released, waiting for locked_s, timeout running
// ST_LOCK_STABLE | counting consecutive locked_s samples
// ST_RELEASE     | stages released every STAGE_DELAY cycles
// ST_RUN         | all stages released, o_all_ready high
// ST_FAULT       | retry limit reached; PLL held in reset until i_reset
module pll_reset_sequencer #(
  parameter int NUM_STAGES          = 3,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 33_000_000,
  parameter int STAGE_DELAY         = 64,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pll_locked,
  output logic                  o_pll_reset,
  output logic [NUM_STAGES-1:0] o_stage_reset_n,
  output logic                  o_all_ready,
  output logic [7:0]            o_lock_lost_count,
  output logic                  o_fault
);

  localparam int RST_W = (PLL_RESET_CYCLES > 1) ? $clog2(PLL_RESET_CYCLES) : 1;
  localparam int TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int DLY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RESET_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);

  typedef enum logic [2:0] {
    ST_PLL_RESET   = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_STABLE = 3'd2,
    ST_RELEASE     = 3'd3,
    ST_RUN         = 3'd4
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    , ST_FAULT     = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, locked_s_q;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [STB_W-1:0]      stb_cnt_q, stb_cnt_d;
  logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
  logic                  pll_reset_q, pll_reset_d;
  logic [NUM_STAGES-1:0] stage_n_q, stage_n_d;
  logic                  all_ready_q, all_ready_d;
  logic [7:0]            lost_q, lost_d;
  logic                  lock_loss;

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fault_q, fault_d;
`else
  // The retry limit only exists in the FAULT-capable build.
  localparam int unused_max_retries = MAX_RETRIES;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    stb_cnt_d = stb_cnt_q;
    dly_cnt_d = dly_cnt_q;
    stage_n_d = stage_n_q;
    lost_d    = lost_q;
    lock_loss = 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      ST_PLL_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d   = ST_LOCK_STABLE;
          stb_cnt_d = '0;
        end else if (timeout_q) begin
          rst_cnt_d = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          if (retry_q == RETRY_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_PLL_RESET;
            retry_d = retry_q + 1'b1;
          end
`else
          state_d = ST_PLL_RESET;
`endif
        end else if (to_cnt_q == TO_LAST) begin
          // Expiry is registered off the terminal count, so each attempt
          // spends LOCK_TIMEOUT_CYCLES+1 cycles here before the PLL restarts.
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_LOCK_STABLE: begin
        if (!locked_s_q) begin
          // A glitch before release is a failed qualification, not a loss.
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = '0;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d   = ST_RELEASE;
          stage_n_d = NUM_STAGES'(1);
          dly_cnt_d = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          retry_d   = '0;
`endif
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!locked_s_q) begin
          lock_loss = 1'b1;
        end else if (&stage_n_q) begin
          state_d = ST_RUN;
        end else if (dly_cnt_q == DLY_LAST) begin
          // Shift in a one: released stages stay released.
          stage_n_d = (stage_n_q << 1) | NUM_STAGES'(1);
          dly_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s_q) lock_loss = 1'b1;
      end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      ST_FAULT: begin
        stage_n_d = '0;
      end
`endif
      default: begin
        state_d   = ST_PLL_RESET;
        rst_cnt_d = '0;
        stage_n_d = '0;
      end
    endcase

    if (lock_loss) begin
      state_d   = ST_PLL_RESET;
      rst_cnt_d = '0;
      stage_n_d = '0;
      if (lost_q != 8'hFF) lost_d = lost_q + 1'b1;
    end

    all_ready_d = (state_d == ST_RUN);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    fault_d     = (state_d == ST_FAULT);
    pll_reset_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
`else
    pll_reset_d = (state_d == ST_PLL_RESET);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_PLL_RESET;
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      stb_cnt_q   <= '0;
      dly_cnt_q   <= '0;
      pll_reset_q <= 1'b1;
      stage_n_q   <= '0;
      all_ready_q <= 1'b0;
      lost_q      <= '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      retry_q     <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= i_pll_locked;
      locked_s_q  <= sync1_q;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
      stb_cnt_q   <= stb_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      pll_reset_q <= pll_reset_d;
      stage_n_q   <= stage_n_d;
      all_ready_q <= all_ready_d;
      lost_q      <= lost_d;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      retry_q     <= retry_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign o_pll_reset       = pll_reset_q;
  assign o_stage_reset_n   = stage_n_q;
  assign o_all_ready       = all_ready_q;
  assign o_lock_lost_count = lost_q;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  assign o_fault           = fault_q;
`else
  assign o_fault           = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;
  localparam int NS  = 3;
  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int TOC = 50;
  localparam int SD  = 4;
  localparam int MR  = 2;

  localparam int MP_RESET = 0;
  localparam int MP_WAIT  = 1;
  localparam int MP_STAB  = 2;
  localparam int MP_REL   = 3;
  localparam int MP_RUN   = 4;
  localparam int MP_FAULT = 5;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_pll_locked = 1'b0;
  logic          o_pll_reset;
  logic [NS-1:0] o_stage_reset_n;
  logic          o_all_ready;
  logic [7:0]    o_lock_lost_count;
  logic          o_fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: phase plus elapsed edges since phase entry
  int m_s1, m_s2, m_phase, m_el, m_lost, m_retry;

  pll_reset_sequencer #(
    .NUM_STAGES(NS), .PLL_RESET_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT_CYCLES(TOC), .STAGE_DELAY(SD), .MAX_RETRIES(MR)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pll_locked(i_pll_locked),
    .o_pll_reset(o_pll_reset), .o_stage_reset_n(o_stage_reset_n),
    .o_all_ready(o_all_ready), .o_lock_lost_count(o_lock_lost_count),
    .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic lock_lost_event();
    m_lost  = (m_lost < 255) ? m_lost + 1 : 255;
    m_phase = MP_RESET;
    m_el    = 0;
  endtask

  task automatic model_edge(input logic r, input logic l);
    int ls;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_phase = MP_RESET; m_el = 0; m_lost = 0; m_retry = 0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(l);
      case (m_phase)
        MP_RESET: begin
          m_el++;
          if (m_el == PRC) begin m_phase = MP_WAIT; m_el = 0; end
        end
        MP_WAIT: begin
          if (ls != 0) begin
            m_phase = MP_STAB; m_el = 0;
          end else begin
            m_el++;
            if (m_el == TOC + 1) begin
              m_retry++;
              m_el = 0;
              m_phase = MP_RESET;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
              if (m_retry >= MR) m_phase = MP_FAULT;
`endif
            end
          end
        end
        MP_STAB: begin
          if (ls == 0) begin
            m_phase = MP_WAIT; m_el = 0;
          end else begin
            m_el++;
            if (m_el == LSC) begin m_phase = MP_REL; m_el = 0; m_retry = 0; end
          end
        end
        MP_REL: begin
          if (ls == 0) lock_lost_event();
          else begin
            m_el++;
            if (m_el == (NS - 1) * SD + 1) begin m_phase = MP_RUN; m_el = 0; end
          end
        end
        MP_RUN: if (ls == 0) lock_lost_event();
        default: ;
      endcase
    end
  endtask

  function automatic int exp_st();
    int k;
    if (m_phase == MP_RUN) return (1 << NS) - 1;
    if (m_phase != MP_REL) return 0;
    k = m_el / SD + 1;
    if (k > NS) k = NS;
    return (1 << k) - 1;
  endfunction

  task automatic step(input logic r, input logic l);
    @(negedge clk);
    i_reset = r;
    i_pll_locked = l;
    @(posedge clk);
    model_edge(r, l);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    check("mdl_pll_reset", int'(o_pll_reset), int'(m_phase == MP_RESET || m_phase == MP_FAULT));
    check("mdl_stages", int'(o_stage_reset_n), exp_st());
    check("mdl_ready", int'(o_all_ready), int'(m_phase == MP_RUN));
    check("mdl_lost", int'(o_lock_lost_count), m_lost);
    check("mdl_fault", int'(o_fault), int'(m_phase == MP_FAULT));
  endtask

  typedef struct {
    logic       rst;
    logic       lock;
    int         reps;
    logic       pr;
    logic [2:0] st;
    logic       rdy;
    logic [7:0] lost;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int bad, rises, prev, found, len;
    logic lk, exp_pr, exp_f;

    // power-up release (lock high from cycle 0), then lock drop in RUN and recovery
    tbl[0]  = '{1'b1, 1'b1, 2, 1'b1, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 3, 1'b1, 3'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 9, 1'b0, 3'd0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 4, 1'b0, 3'd1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 4, 1'b0, 3'd3, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1, 1'b0, 3'd7, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 5, 1'b0, 3'd7, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 2, 1'b0, 3'd7, 1'b1, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1, 1'b1, 3'd0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b1, 3, 1'b1, 3'd0, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 9, 1'b0, 3'd0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 4, 1'b0, 3'd1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b1, 4, 1'b0, 3'd3, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 1, 1'b0, 3'd7, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 1'b1, 3, 1'b0, 3'd7, 1'b1, 8'd1};

    for (int v = 0; v < 15; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(tbl[v].rst, tbl[v].lock);
        check($sformatf("tbl%0d_pll_reset", v), int'(o_pll_reset), int'(tbl[v].pr));
        check($sformatf("tbl%0d_stages", v), int'(o_stage_reset_n), int'(tbl[v].st));
        check($sformatf("tbl%0d_ready", v), int'(o_all_ready), int'(tbl[v].rdy));
        check($sformatf("tbl%0d_lost", v), int'(o_lock_lost_count), int'(tbl[v].lost));
        check($sformatf("tbl%0d_fault", v), int'(o_fault), 0);
      end
    end

    // second lock loss from RUN, then reset while stages read 011
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("t6_lost2", int'(o_lock_lost_count), 2);
    check("t6_loss_stages", int'(o_stage_reset_n), 0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step(1'b0, 1'b1);
      if (o_stage_reset_n == 3'b011) found = 1;
    end
    check("t6_reach_011", found, 1);
    step(1'b1, 1'b1);
    check("t6_rst_pll_reset", int'(o_pll_reset), 1);
    check("t6_rst_stages", int'(o_stage_reset_n), 0);
    check("t6_rst_ready", int'(o_all_ready), 0);
    check("t6_rst_lost", int'(o_lock_lost_count), 0);
    check("t6_rst_fault", int'(o_fault), 0);

    // 1-cycle glitch after 5 stable samples: release slips from cycle 13 to 20
    bad = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, (n != 9));
      if (n < 20 && o_stage_reset_n != 3'b000) bad++;
    end
    check("t2_no_early_release", bad, 0);
    check("t2_release_at_20", int'(o_stage_reset_n), 1);
    check("t2_lost_zero", int'(o_lock_lost_count), 0);

    // lock never asserts
    step(1'b1, 1'b0);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    bad = 0;
    for (int n = 1; n <= 160; n++) begin
      step(1'b0, 1'b0);
      exp_pr = (n < 110) ? ((n % 55) < 4) : 1'b1;
      exp_f  = (n >= 110);
      if (o_pll_reset != exp_pr || o_fault != exp_f || o_stage_reset_n != 3'b000) bad++;
    end
    check("t5_fault_pattern", bad, 0);
    check("t5_fault_set", int'(o_fault), 1);
    step(1'b1, 1'b0);
    check("t5_rst_fault", int'(o_fault), 0);
    check("t5_rst_pll_reset", int'(o_pll_reset), 1);
    for (int n = 1; n <= 13; n++) begin
      step(1'b0, 1'b1);
      if (n == 12) check("t5_restart_hold", int'(o_stage_reset_n), 0);
    end
    check("t5_restart_release", int'(o_stage_reset_n), 1);
`else
    bad = 0;
    rises = 0;
    prev = 1;
    for (int n = 1; n <= 300; n++) begin
      step(1'b0, 1'b0);
      exp_pr = ((n % 55) < 4);
      if (o_pll_reset != exp_pr) bad++;
      if (o_fault != 1'b0 || o_stage_reset_n != 3'b000) bad++;
      if (prev == 0 && o_pll_reset == 1'b1) rises++;
      prev = int'(o_pll_reset);
    end
    check("t4_pulse_pattern", bad, 0);
    check("t4_pulse_count", rises, 5);
    check("t4_fault_zero", int'(o_fault), 0);
`endif

    // randomized lock behaviour against the reference model
    step(1'b1, 1'b0);
    check_model();
    for (int n = 0; n < 4000; ) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, $urandom_range(0, 1) == 1);
        check_model();
        n++;
      end
      if ($urandom_range(0, 3) != 0) begin
        lk  = 1'b1;
        len = $urandom_range(1, 60);
      end else begin
        lk  = 1'b0;
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(40, 130) : $urandom_range(1, 6);
      end
      for (int i = 0; i < len && n < 4000; i++) begin
        step(1'b0, lk);
        check_model();
        n++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
